// File: rtl/tap_pattern_decoder_pkg.sv
// tap_pattern_decoder_pkg: default tap delays, holdoff, counter width and FSM state encodings
package tap_pattern_decoder_pkg;
  localparam int DEF_TAP0 = 0;
  localparam int DEF_TAP1 = 2;
  localparam int DEF_TAP2 = 8;
  localparam int DEF_HOLDOFF = 8;
  localparam int DEF_CNT_W = 8;
  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;
  function automatic int win_len(input int tap2);
    return tap2 + 1;
  endfunction
endpackage

// File: rtl/tap_pattern_decoder_if.sv
// tap_pattern_decoder_if: line/enable inputs and decode outputs; master drives en/line_in, slave is the decoder
interface tap_pattern_decoder_if
  import tap_pattern_decoder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic en;
  logic line_in;
  logic dec_pulse;
  logic busy;
  logic [CNT_W-1:0] dec_cnt;
  logic coll_pulse;
  modport master(output en, line_in, input dec_pulse, busy, dec_cnt, coll_pulse);
  modport slave(input en, line_in, output dec_pulse, busy, dec_cnt, coll_pulse);
endinterface

// File: rtl/tap_pattern_decoder_window_sr.sv
// tap_window_sr: WIN-bit sliding window (clk, rst, en, d in; q out), newest sample in q[0]
module tap_window_sr #(
  parameter int WIN = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic [WIN-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= {q[WIN-2:0], d};
endmodule

// File: rtl/tap_pattern_decoder.sv
// tap_pattern_decoder: correlates a sliding window against the 3-tap pattern; ports clk, rst, bus (slave: en, line_in -> dec_pulse, busy, dec_cnt, coll_pulse); strict collision check enabled by TAP_DECODE_STRICT_EN
module tap_pattern_decoder
  import tap_pattern_decoder_pkg::*;
#(
  parameter int TAP0 = DEF_TAP0,
  parameter int TAP1 = DEF_TAP1,
  parameter int TAP2 = DEF_TAP2,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  tap_pattern_decoder_if.slave bus
);
  localparam int WIN = win_len(TAP2);
  localparam int BW = $clog2(HOLDOFF + 1);
  localparam logic [WIN-1:0] TAP_MASK = WIN'((1 << (TAP2 - TAP0)) | (1 << (TAP2 - TAP1)) | 1);
  logic [WIN-1:0] sr;
  logic [0:0] state;
  logic [BW-1:0] blank_cnt;
  logic [CNT_W-1:0] dec_cnt;
  logic dec_pulse, coll_pulse, taps, match, coll_hit, hunt;
  tap_window_sr #(.WIN(WIN)) u_sr (.clk(clk), .rst(rst), .en(bus.en), .d(bus.line_in), .q(sr));
  assign taps = &(sr | ~TAP_MASK);
`ifdef TAP_DECODE_STRICT_EN
  logic extra;
  assign extra = |(sr & ~TAP_MASK);
  assign match = taps & ~extra;
  assign coll_hit = taps & extra;
`else
  assign match = taps;
  assign coll_hit = 1'b0;
`endif
  assign hunt = state == ST_HUNT;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_HUNT;
      blank_cnt <= '0;
      dec_pulse <= 1'b0;
      coll_pulse <= 1'b0;
      dec_cnt <= '0;
    end else begin
      dec_pulse <= bus.en & hunt & match;
      coll_pulse <= bus.en & hunt & coll_hit;
      if (bus.en) begin
        if (hunt && match) begin
          state <= ST_BLANK;
          blank_cnt <= BW'(HOLDOFF - 1);
          dec_cnt <= dec_cnt + CNT_W'(dec_cnt != '1);
        end else if (!hunt) begin
          // a match seen on the final blank cycle is dropped; HUNT is re-entered first
          state <= blank_cnt == '0 ? ST_HUNT : ST_BLANK;
          blank_cnt <= blank_cnt == '0 ? '0 : blank_cnt - 1'b1;
        end
      end
    end
  assign bus.dec_pulse = dec_pulse;
  assign bus.coll_pulse = coll_pulse;
  assign bus.busy = state == ST_BLANK;
  assign bus.dec_cnt = dec_cnt;
endmodule

// File: tb/tb_tap_pattern_decoder.sv
// tb_tap_pattern_decoder: directed stimulus, per-cycle model comparison and literal checks for tap_pattern_decoder
module tb_tap_pattern_decoder;
  localparam int HOLDOFF = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int qs[$];
  always #5 clk = ~clk;
  tap_pattern_decoder_if #(.CNT_W(8)) b();
  tap_pattern_decoder_if #(.CNT_W(2)) b_s();
  assign b_s.en = b.en;
  assign b_s.line_in = b.line_in;
  tap_pattern_decoder #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
  tap_pattern_decoder #(.CNT_W(2)) dut_s (.clk(clk), .rst(rst), .bus(b_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: the window is the last 9 enabled samples; a decode is allowed only
  // HOLDOFF+1 enabled edges after the previous one, busy spans HOLDOFF edges
  int w[9];
  int n, last_dec, m_cnt, m_cnt_s;
  logic m_dec, m_coll, m_busy, mok = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      foreach (w[i]) w[i] = 0;
      n = 0;
      last_dec = -1000;
      m_cnt = 0;
      m_cnt_s = 0;
      m_dec = 1'b0;
      m_coll = 1'b0;
      mok = 1'b1;
    end else begin
      m_dec = 1'b0;
      m_coll = 1'b0;
      if (b.en) begin
        int others;
        bit taps, ready;
        n++;
        taps = w[8] == 1 && w[6] == 1 && w[0] == 1;
        others = 0;
        foreach (w[i]) if (i != 0 && i != 6 && i != 8) others += w[i];
        ready = n >= last_dec + HOLDOFF + 1;
`ifdef TAP_DECODE_STRICT_EN
        if (ready && taps && others > 0) m_coll = 1'b1;
        else if (ready && taps) m_dec = 1'b1;
`else
        if (ready && taps) m_dec = 1'b1;
`endif
        if (m_dec) begin
          last_dec = n;
          m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
          m_cnt_s = m_cnt_s < 3 ? m_cnt_s + 1 : 3;
        end
        for (int i = 8; i > 0; i--) w[i] = w[i-1];
        w[0] = int'(b.line_in);
      end
    end
    m_busy = n >= last_dec && n <= last_dec + HOLDOFF - 1;
  end

  always @(negedge clk)
    if (mok) begin
      chk("dec_pulse", 32'(b.dec_pulse), 32'(m_dec));
      chk("busy", 32'(b.busy), 32'(m_busy));
      chk("coll_pulse", 32'(b.coll_pulse), 32'(m_coll));
      chk("dec_cnt", 32'(b.dec_cnt), 32'(m_cnt));
      chk("dec_cnt_w2", 32'(b_s.dec_cnt), 32'(m_cnt_s));
      chk("dec_pulse_w2", 32'(b_s.dec_pulse), 32'(m_dec));
    end

  task automatic cyc(input logic e, input logic l, input logic r);
    b.en = e;
    b.line_in = l;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bits3(input int x, input int y, input int z);
    return (128'(1) << x) | (128'(1) << y) | (128'(1) << z);
  endfunction

  task automatic send(input logic [127:0] pat, input logic [127:0] enp, input int len,
                      output int ndec, output int nbusy, output int ncoll, output int first);
    ndec = 0;
    nbusy = 0;
    ncoll = 0;
    first = -1;
    qs.delete();
    for (int c = 0; c < len; c++) begin
      cyc(enp[c], pat[c], 1'b0);
      if (b.dec_pulse) begin
        ndec++;
        if (first < 0) first = c;
        qs.push_back(int'(b_s.dec_cnt));
      end
      nbusy += int'(b.busy);
      ncoll += int'(b.coll_pulse);
    end
  endtask

  int nd, nb, nc, fd;
  logic [127:0] p;
  initial begin
    b.en = 1'b0;
    b.line_in = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    chk("reset dec_pulse", 32'(b.dec_pulse), 0);
    chk("reset busy", 32'(b.busy), 0);
    chk("reset dec_cnt", 32'(b.dec_cnt), 0);
    chk("reset coll", 32'(b.coll_pulse), 0);
    // single codeword
    send(bits3(10, 12, 18), '1, 40, nd, nb, nc, fd);
    chk("t1 ndec", nd, 1);
    chk("t1 first", fd, 19);
    chk("t1 busy cycles", nb, 8);
    chk("t1 dec_cnt", 32'(b.dec_cnt), 1);
    // line held high
    cyc(1'b1, 1'b0, 1'b1);
    send((128'(1) << 40) - 1, '1, 60, nd, nb, nc, fd);
    chk("t2 ndec", nd, 4);
    chk("t2 first", fd, 9);
    chk("t2 dec_cnt", 32'(b.dec_cnt), 4);
    // partial patterns
    cyc(1'b1, 1'b0, 1'b1);
    send((128'(1) << 0) | (128'(1) << 2) | (128'(1) << 20) | (128'(1) << 28), '1, 50, nd, nb, nc, fd);
    chk("t3 ndec", nd, 0);
    chk("t3 busy", nb, 0);
    chk("t3 dec_cnt", 32'(b.dec_cnt), 0);
    // saturation on the 2-bit counter
    cyc(1'b1, 1'b0, 1'b1);
    p = '0;
    for (int i = 0; i < 5; i++) p |= bits3(20 * i, 20 * i + 2, 20 * i + 8);
    send(p, '1, 110, nd, nb, nc, fd);
    chk("t4 ndec", nd, 5);
    chk("t4 qlen", qs.size(), 5);
    if (qs.size() == 5) begin
      chk("t4 cnt1", qs[0], 1);
      chk("t4 cnt2", qs[1], 2);
      chk("t4 cnt3", qs[2], 3);
      chk("t4 cnt4", qs[3], 3);
      chk("t4 cnt5", qs[4], 3);
    end
    chk("t4 wide cnt", 32'(b.dec_cnt), 5);
    // reset during blanking
    cyc(1'b1, 1'b0, 1'b1);
    p = bits3(10, 12, 18);
    for (int c = 0; c <= 22; c++) cyc(1'b1, p[c], 1'b0);
    chk("t5 busy before rst", 32'(b.busy), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t5 busy after rst", 32'(b.busy), 0);
    chk("t5 cnt after rst", 32'(b.dec_cnt), 0);
    send(bits3(3, 5, 11), '1, 30, nd, nb, nc, fd);
    chk("t5 fresh ndec", nd, 1);
    chk("t5 fresh first", fd, 12);
    // extra pulse inside the window
    cyc(1'b1, 1'b0, 1'b1);
    send(bits3(0, 2, 8) | (128'(1) << 5), '1, 20, nd, nb, nc, fd);
`ifdef TAP_DECODE_STRICT_EN
    chk("t6 coll", nc, 1);
    chk("t6 ndec", nd, 0);
    chk("t6 busy", nb, 0);
    chk("t6 dec_cnt", 32'(b.dec_cnt), 0);
`else
    chk("t6 coll", nc, 0);
    chk("t6 ndec", nd, 1);
    chk("t6 dec_cnt", 32'(b.dec_cnt), 1);
`endif
    // enable gap between second and third pulse
    cyc(1'b1, 1'b0, 1'b1);
    send(bits3(0, 2, 13), ~(128'h1f << 3), 30, nd, nb, nc, fd);
    chk("t7 ndec", nd, 1);
    chk("t7 first", fd, 14);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
